// File: rtl/led_fader_pkg.sv
// Shared types and constants for the LED brightness fader.
package led_fader_pkg;

    localparam int unsigned PWM_BITS = 8;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        FADE_IN  = 2'd1,
        ON       = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    // Perceptual brightness curve: round-up square scaled back to 8 bits.
    function automatic logic [PWM_BITS-1:0] gamma8(input logic [PWM_BITS-1:0] lv);
        logic [15:0] sq;
        sq = 16'(lv) * 16'(lv);
        return PWM_BITS'((sq + 16'd255) >> 8);
    endfunction

endpackage

// File: rtl/led_fader_pwm_gen.sv
// Glitch-free PWM: duty is sampled only at the period boundary.
module pwm_gen
    import led_fader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm
);

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            if (r_cnt == '1) begin
                r_duty <= duty;
            end
            r_pwm <= (r_cnt < r_duty);
        end
    end

    assign pwm = r_pwm;

endmodule

// File: rtl/led_fader.sv
// On/off fader with linear ramps driving one PWM LED pin.
// Optional gamma curve on the dial level: define LED_FADER_GAMMA_EN.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned FADE_DIV_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PWM_BITS-1:0] level,
    input  logic                button_n,
    output logic                pwm,
    output logic [1:0]          state,
    output logic                busy
);

    logic                     r_btn_prev;
    logic [FADE_DIV_BITS-1:0] r_fade_cnt;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [PWM_BITS-1:0]      r_cur;
    logic [PWM_BITS-1:0]      w_cur_nxt;
    logic [PWM_BITS-1:0]      w_eff;
    logic [PWM_BITS-1:0]      w_tgt;
    logic                     r_busy;
    logic                     w_press;
    logic                     w_tick;

    // A button already low when reset releases never looks like a press.
    assign w_press = r_btn_prev & ~button_n;
    assign w_tick  = &r_fade_cnt;

`ifdef LED_FADER_GAMMA_EN
    assign w_eff = gamma8(level);
`else
    assign w_eff = level;
`endif

    assign w_tgt = (r_state == FADE_IN || r_state == ON) ? w_eff : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= OFF;
            r_cur      <= '0;
            r_busy     <= 1'b0;
            r_btn_prev <= 1'b0;
            r_fade_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_busy     <= (w_state_nxt == FADE_IN) || (w_state_nxt == FADE_OUT);
            r_btn_prev <= button_n;
            r_fade_cnt <= r_fade_cnt + FADE_DIV_BITS'(1);
        end
    end

    // A press outranks every other transition in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        case (r_state)
            OFF: begin
                w_cur_nxt = '0;
                if (w_press) w_state_nxt = FADE_IN;
            end
            FADE_IN: begin
                if (w_press) begin
                    w_state_nxt = FADE_OUT;
                end else if (r_cur == w_tgt) begin
                    w_state_nxt = ON;
                end else if (w_tick) begin
                    w_cur_nxt = (r_cur < w_tgt) ? r_cur + PWM_BITS'(1) : r_cur - PWM_BITS'(1);
                end
            end
            ON: begin
                w_cur_nxt = w_tgt;
                if (w_press) w_state_nxt = FADE_OUT;
            end
            FADE_OUT: begin
                if (w_press) begin
                    w_state_nxt = FADE_IN;
                end else if (r_cur == '0) begin
                    w_state_nxt = OFF;
                end else if (w_tick) begin
                    w_cur_nxt = r_cur - PWM_BITS'(1);
                end
            end
            default: begin
                w_state_nxt = OFF;
                w_cur_nxt   = '0;
            end
        endcase
    end

    assign state = r_state;
    assign busy  = r_busy;

    pwm_gen u_pwm (
        .clk  (clk),
        .rst  (rst),
        .duty (r_cur),
        .pwm  (pwm)
    );

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader with a 4-cycle fade tick.
module tb_led_fader;

    logic       clk;
    logic       rst;
    logic [7:0] level;
    logic       button_n;
    logic       pwm;
    logic [1:0] state;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] S_OFF = 2'd0, S_FIN = 2'd1, S_ON = 2'd2, S_FOUT = 2'd3;

    led_fader #(.FADE_DIV_BITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .level    (level),
        .button_n (button_n),
        .pwm      (pwm),
        .state    (state),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int eff_of(input int lv);
`ifdef LED_FADER_GAMMA_EN
        return (lv * lv + 255) / 256;
`else
        return lv;
`endif
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        button_n = 1'b0;
        step(1);
        button_n = 1'b1;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp);
        int k = 0;
        while (state != exp && k < 4000) begin
            step(1);
            k++;
        end
        check_eq(tag, int'(state), int'(exp));
    endtask

    task automatic wait_cur(input string tag, input int exp);
        int k = 0;
        while (int'(dut.r_cur) != exp && k < 4000) begin
            step(1);
            k++;
        end
        check_eq(tag, int'(dut.r_cur), exp);
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        repeat (256) begin
            step(1);
            hi += int'(pwm);
        end
    endtask

    initial begin
        int hi;
        int bad_state;
        rst      = 1'b1;
        button_n = 1'b0;
        level    = 8'd200;
        step(3);
        rst = 1'b0;
        check_eq("rst_state", int'(state), S_OFF);
        check_eq("rst_pwm", int'(pwm), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_cur", int'(dut.r_cur), 0);

        // Held button through reset: nothing happens for 1000 cycles.
        hi = 0;
        bad_state = 0;
        repeat (1000) begin
            step(1);
            hi += int'(pwm);
            if (state != S_OFF) bad_state++;
        end
        check_eq("held_pwm_high", hi, 0);
        check_eq("held_state_moves", bad_state, 0);
        button_n = 1'b1;
        step(2);

        // Fade in to 100.
        level = 8'd100;
        press();
        check_eq("fin_state", int'(state), S_FIN);
        check_eq("fin_busy", int'(busy), 1);
        check_eq("fin_cur0", int'(dut.r_cur), 0);
        step(8);
        check_eq("fin_cur_2ticks", int'(dut.r_cur), 2);
        wait_state("fin_reach_on", S_ON);
        check_eq("on_cur", int'(dut.r_cur), eff_of(100));
        check_eq("on_busy", int'(busy), 0);
        step(300);
        count_high(hi);
        check_eq("on_duty100", hi, eff_of(100));

        // Dial followed immediately in ON.
        level = 8'd20;
        step(1);
        check_eq("follow_cur", int'(dut.r_cur), eff_of(20));
        step(300);
        count_high(hi);
        check_eq("follow_duty20", hi, eff_of(20));

        press();
        check_eq("fout_state", int'(state), S_FOUT);
        wait_state("fout_off", S_OFF);
        check_eq("fout_cur0", int'(dut.r_cur), 0);

        // Reverse mid-fade at cur=50.
        level = 8'd200;
        press();
        wait_cur("rev_reach50", 50);
        check_eq("rev_still_fin", int'(state), S_FIN);
        press();
        check_eq("rev_state", int'(state), S_FOUT);
        check_eq("rev_cur_held", int'(dut.r_cur), 50);
        step(8);
        check_eq("rev_cur_down", int'(dut.r_cur), 48);
        wait_state("rev_off", S_OFF);
        check_eq("rev_cur0", int'(dut.r_cur), 0);
        step(300);
        count_high(hi);
        check_eq("rev_pwm_dark", hi, 0);

        // Level 0: straight to ON with a dark LED.
        level = 8'd0;
        press();
        check_eq("lvl0_fin", int'(state), S_FIN);
        step(1);
        check_eq("lvl0_on", int'(state), S_ON);
        check_eq("lvl0_cur", int'(dut.r_cur), 0);
        step(300);
        count_high(hi);
        check_eq("lvl0_dark", hi, 0);

        // Full brightness: 255 of 256.
        level = 8'd255;
        step(1);
        check_eq("lvl255_cur", int'(dut.r_cur), 255);
        step(300);
        count_high(hi);
        check_eq("lvl255_duty", hi, 255);

        press();
        wait_state("to_off", S_OFF);

        // Press arriving exactly when cur reaches tgt wins over ON.
        level = 8'd5;
        press();
        wait_cur("tie_reach", eff_of(5));
        check_eq("tie_still_fin", int'(state), S_FIN);
        press();
        check_eq("tie_press_wins", int'(state), S_FOUT);
        wait_state("tie_off", S_OFF);

`ifdef LED_FADER_GAMMA_EN
        level = 8'd128;
        press();
        wait_state("gamma_on", S_ON);
        check_eq("gamma_128", int'(dut.r_cur), 64);
        level = 8'd1;
        step(1);
        check_eq("gamma_1", int'(dut.r_cur), 1);
`endif

        // Reset mid-fade.
        level = 8'd200;
        press();
        step(20);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("midrst_state", int'(state), S_OFF);
        check_eq("midrst_pwm", int'(pwm), 0);
        check_eq("midrst_cur", int'(dut.r_cur), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
